// File: rtl/tri_color_sequencer.sv
// tri_color_sequencer: R->G->B LED sequencer with programmable per-colour dwell.
// Define TRI_COLOR_PWM_EN to add a free-running PWM dimmer with a writable duty register.
module tri_color_sequencer #(
    parameter int DWELL_W       = 8,
    parameter int DEFAULT_DWELL = 10,
    parameter int PWM_W         = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [DWELL_W-1:0] cfg_data,
    output logic               R,
    output logic               G,
    output logic               B,
    output logic               busy,
    output logic               cycle_done
);
    typedef enum logic [1:0] {IDLE, S_R, S_G, S_B} state_t;

    state_t             state_q, state_d, nxt;
    logic [DWELL_W-1:0] cnt_q, cnt_d, nld;
    logic [DWELL_W-1:0] dr_q, dr_d, dg_q, dg_d, db_q, db_d;
    logic               r_q, r_d, g_q, g_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
    logic               on;
`ifdef TRI_COLOR_PWM_EN
    logic [PWM_W-1:0]   pwm_q, pwm_d, duty_q, duty_d;
`endif

    // A dwell of 0 is held for one cycle, same as 1.
    function automatic logic [DWELL_W-1:0] ld(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nxt     = (state_q == S_R) ? S_G : (state_q == S_G) ? S_B : S_R;
        nld     = (nxt == S_G) ? ld(dg_q) : (nxt == S_B) ? ld(db_q) : ld(dr_q);
        if (state_q == IDLE) begin
            if (start && !stop) begin
                state_d = S_R;
                cnt_d   = ld(dr_q);
            end
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end else begin
            state_d = nxt;
            cnt_d   = nld;
        end
        dr_d = (cfg_we && cfg_sel == 2'd0) ? cfg_data : dr_q;
        dg_d = (cfg_we && cfg_sel == 2'd1) ? cfg_data : dg_q;
        db_d = (cfg_we && cfg_sel == 2'd2) ? cfg_data : db_q;
`ifdef TRI_COLOR_PWM_EN
        pwm_d  = pwm_q + PWM_W'(1);
        duty_d = (cfg_we && cfg_sel == 2'd3) ? cfg_data[PWM_W-1:0] : duty_q;
        on     = pwm_q < duty_q;
`else
        on     = 1'b1;
`endif
        r_d    = (state_d == S_R) && on;
        g_d    = (state_d == S_G) && on;
        b_d    = (state_d == S_B) && on;
        busy_d = state_d != IDLE;
        done_d = (state_q == S_B) && (state_d == S_R);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dr_q    <= DWELL_W'(DEFAULT_DWELL);
            dg_q    <= DWELL_W'(DEFAULT_DWELL);
            db_q    <= DWELL_W'(DEFAULT_DWELL);
            r_q     <= 1'b0;
            g_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TRI_COLOR_PWM_EN
            pwm_q   <= '0;
            duty_q  <= '1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dr_q    <= dr_d;
            dg_q    <= dg_d;
            db_q    <= db_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TRI_COLOR_PWM_EN
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
`endif
        end
    end

    assign R          = r_q;
    assign G          = g_q;
    assign B          = b_q;
    assign busy       = busy_q;
    assign cycle_done = done_q;
endmodule
